gate_reduce_pipe: RTL and testbench

Parametrised, pipelined N-input reduction gate with per-input bubble inversion, run-time selectable operation (AND/OR/XOR/NOR), a valid-tagged output pipeline, rising-edge detection and a saturating hit counter. It sits in the hazard and condition-detect paths of the redirection pipeline. It replaces fixed-width combinational AND/OR gates wherever a registered, qualified condition plus an event count is needed, for example BTB hit/mispredict monitoring.

---
 rtl/gate_pkg.sv | 26 ++
 rtl/gate_reduce_comb.sv | 33 +++
 rtl/gate_reduce_pipe.sv | 105 ++++++++++
 tb/tb_gate_reduce_pipe.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// gate_pkg: shared mode encodings, parameter limits and stage record type.
// Revision: 1.0
// ----------------------------------------------------------------------------
package gate_pkg;

  localparam logic [1:0] GATE_AND = 2'b00;
  localparam logic [1:0] GATE_OR  = 2'b01;
  localparam logic [1:0] GATE_XOR = 2'b10;
  localparam logic [1:0] GATE_NOR = 2'b11;

  localparam int MIN_INPUTS      = 2;
  localparam int MAX_INPUTS      = 32;
  localparam int MIN_STAGES      = 1;
  localparam int MAX_STAGES      = 4;
  localparam int MIN_COUNT_WIDTH = 2;
  localparam int MAX_COUNT_WIDTH = 16;

  typedef struct packed {
    logic valid;
    logic result;
  } stage_t;

endpackage
`default_nettype wire

// File: rtl/gate_reduce_comb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// gate_reduce_comb: bubble inversion followed by mode-selected reduction.
// Revision: 1.0
// ----------------------------------------------------------------------------
module gate_reduce_comb
  import gate_pkg::*;
#(
  parameter int                      NR_OF_INPUTS = 4,
  parameter logic [NR_OF_INPUTS-1:0] BubblesMask  = '0
) (
  input  logic [NR_OF_INPUTS-1:0] inputs_i,
  input  logic [1:0]              mode_i,
  output logic                    result_o
);

  logic [NR_OF_INPUTS-1:0] real_inputs;

  assign real_inputs = inputs_i ^ BubblesMask;

  always_comb begin
    result_o = 1'b0;
    case (mode_i)
      GATE_AND: result_o = &real_inputs;
      GATE_OR:  result_o = |real_inputs;
      GATE_XOR: result_o = ^real_inputs;
      GATE_NOR: result_o = ~|real_inputs;
      default:  result_o = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/gate_reduce_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// gate_reduce_pipe: pipelined reduction gate with rise detect and hit counter.
// Revision: 1.0
// ----------------------------------------------------------------------------
module gate_reduce_pipe
  import gate_pkg::*;
#(
  parameter int                      NR_OF_INPUTS = 4,
  parameter logic [NR_OF_INPUTS-1:0] BubblesMask  = '0,
  parameter int                      PIPE_STAGES  = 2,
  parameter int                      COUNT_WIDTH  = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NR_OF_INPUTS-1:0] inputs_i,
  input  logic                    in_valid_i,
  input  logic [1:0]              mode_i,
  input  logic                    clear_count_i,
  output logic                    result_o,
  output logic                    out_valid_o,
  output logic                    rise_o,
  output logic [COUNT_WIDTH-1:0]  hit_count_o,
  output logic                    count_sat_o
);

  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  logic                   reduced;
  stage_t                 stage_q [PIPE_STAGES];
  stage_t                 stage_d [PIPE_STAGES];
  logic                   prev_q;
  logic                   prev_d;
  logic [COUNT_WIDTH-1:0] count_q;
  logic [COUNT_WIDTH-1:0] count_d;

  gate_reduce_comb #(
    .NR_OF_INPUTS (NR_OF_INPUTS),
    .BubblesMask  (BubblesMask)
  ) u_reduce (
    .inputs_i (inputs_i),
    .mode_i   (mode_i),
    .result_o (reduced)
  );

  // Free-running shift: every stage advances each cycle, bubbles included.
  always_comb begin
    stage_d[0].valid  = in_valid_i;
    stage_d[0].result = reduced;
    for (int k = 1; k < PIPE_STAGES; k++) begin
      stage_d[k] = stage_q[k-1];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < PIPE_STAGES; k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign out_valid_o = stage_q[PIPE_STAGES-1].valid;
  assign result_o    = stage_q[PIPE_STAGES-1].result;
  assign count_sat_o = &count_q;
  assign hit_count_o = count_q;

  // Bubbles leave the remembered result untouched so 1,gap,1 is one rise.
  assign rise_o = out_valid_o & result_o & ~prev_q;

  always_comb begin
    prev_d = prev_q;
    if (out_valid_o) begin
      prev_d = result_o;
    end

    count_d = count_q;
    if (clear_count_i) begin
      count_d = '0;
    end else if (out_valid_o && result_o && !count_sat_o) begin
      count_d = count_q + COUNT_ONE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_q  <= 1'b0;
      count_q <= '0;
    end else begin
      prev_q  <= prev_d;
      count_q <= count_d;
    end
  end

  a_inputs_range: assert property (@(posedge clk_i)
    (NR_OF_INPUTS >= MIN_INPUTS) && (NR_OF_INPUTS <= MAX_INPUTS));
  a_stages_range: assert property (@(posedge clk_i)
    (PIPE_STAGES >= MIN_STAGES) && (PIPE_STAGES <= MAX_STAGES));
  a_count_range: assert property (@(posedge clk_i)
    (COUNT_WIDTH >= MIN_COUNT_WIDTH) && (COUNT_WIDTH <= MAX_COUNT_WIDTH));

endmodule
`default_nettype wire

// File: tb/tb_gate_reduce_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_gate_reduce_pipe: directed stimulus checked against a sample-history model.
// Revision: 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_gate_reduce_pipe;
  import gate_pkg::*;

  localparam int         NI = 4;
  localparam int         PS = 2;
  localparam int         CW = 3;
  localparam logic [3:0] BM = 4'b0001;
  localparam int         CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NI-1:0] inputs = '0;
  logic          in_valid = 1'b0;
  logic [1:0]    mode = GATE_AND;
  logic          clr = 1'b0;
  logic          result;
  logic          out_valid;
  logic          rise;
  logic [CW-1:0] hit_count;
  logic          count_sat;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  gate_reduce_pipe #(
    .NR_OF_INPUTS (NI),
    .BubblesMask  (BM),
    .PIPE_STAGES  (PS),
    .COUNT_WIDTH  (CW)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .inputs_i      (inputs),
    .in_valid_i    (in_valid),
    .mode_i        (mode),
    .clear_count_i (clr),
    .result_o      (result),
    .out_valid_o   (out_valid),
    .rise_o        (rise),
    .hit_count_o   (hit_count),
    .count_sat_o   (count_sat)
  );

  // Model: every sampling edge appends one sample; a sample is visible PS edges
  // after it was appended, unless a reset happened since it was taken.
  bit hv[$];
  bit hr[$];
  int base  = 0;
  bit m_prev = 1'b0;
  int m_cnt = 0;

  function automatic bit ref_reduce(input logic [3:0] x, input logic [1:0] m);
    logic [3:0] r;
    r = x ^ BM;
    case (m)
      GATE_AND: return (r == 4'hF);
      GATE_OR:  return (r != 4'h0);
      GATE_XOR: return ($countones(r) % 2) == 1;
      default:  return (r == 4'h0);
    endcase
  endfunction

  function automatic void exp_out(output bit v, output bit r);
    int k;
    k = hv.size() - PS;
    v = 1'b0;
    r = 1'b0;
    if (k >= base && k >= 0) begin
      v = hv[k];
      r = hr[k];
    end
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin : model
    bit v;
    bit r;
    if (rst) begin
      base   = hv.size();
      m_prev = 1'b0;
      m_cnt  = 0;
    end else begin
      exp_out(v, r);
      if (clr) m_cnt = 0;
      else if (v && r && m_cnt != CMAX) m_cnt++;
      if (v) m_prev = r;
      hv.push_back(in_valid);
      hr.push_back(ref_reduce(inputs, mode));
    end
  end

  always @(negedge clk) begin : compare
    bit v;
    bit r;
    exp_out(v, r);
    chk("m_out_valid", int'(out_valid), int'(v));
    if (v) chk("m_result", int'(result), int'(r));
    chk("m_result_known", int'($isunknown(result)), 0);
    chk("m_rise", int'(rise), int'(v & r & ~m_prev));
    chk("m_hit_count", int'(hit_count), m_cnt);
    chk("m_count_sat", int'(count_sat), int'(m_cnt == CMAX));
  end

  task automatic step(input logic v, input logic [3:0] in, input logic [1:0] m, input logic c);
    in_valid = v;
    inputs   = in;
    mode     = m;
    clr      = c;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 4'b0000, GATE_AND, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_rise", int'(rise), 0);
    chk("rst_hit", int'(hit_count), 0);
    chk("rst_sat", int'(count_sat), 0);
    rst = 1'b0;

    // AND of real 1111
    step(1'b1, 4'b1110, GATE_AND, 1'b0);
    idle();
    chk("s1_valid", int'(out_valid), 1);
    chk("s1_result", int'(result), 1);
    chk("s1_rise", int'(rise), 1);
    idle();
    chk("s1_hit", int'(hit_count), 1);
    idle();

    // AND real 1110, OR real 0000
    step(1'b1, 4'b1111, GATE_AND, 1'b0);
    step(1'b1, 4'b0001, GATE_OR, 1'b0);
    chk("s2a_valid", int'(out_valid), 1);
    chk("s2a_result", int'(result), 0);
    chk("s2a_rise", int'(rise), 0);
    idle();
    chk("s2b_valid", int'(out_valid), 1);
    chk("s2b_result", int'(result), 0);
    chk("s2b_rise", int'(rise), 0);
    idle();

    // XOR real 0001, NOR real 0000
    step(1'b1, 4'b0000, GATE_XOR, 1'b0);
    step(1'b1, 4'b0001, GATE_NOR, 1'b0);
    chk("s3a_result", int'(result), 1);
    chk("s3a_rise", int'(rise), 1);
    idle();
    chk("s3b_result", int'(result), 1);
    chk("s3b_rise", int'(rise), 0);
    idle();
    chk("s3_hit", int'(hit_count), 3);
    idle();

    // clear, a 0 result, then valid pattern 1,0,1 of ones
    step(1'b1, 4'b1111, GATE_AND, 1'b1);
    step(1'b1, 4'b0000, GATE_OR, 1'b0);
    step(1'b0, 4'b0000, GATE_OR, 1'b0);
    chk("s4a_valid", int'(out_valid), 1);
    chk("s4a_rise", int'(rise), 1);
    step(1'b1, 4'b0000, GATE_OR, 1'b0);
    chk("s4b_valid", int'(out_valid), 0);
    chk("s4b_rise", int'(rise), 0);
    idle();
    chk("s4c_valid", int'(out_valid), 1);
    chk("s4c_rise", int'(rise), 0);
    idle();
    chk("s4_hit", int'(hit_count), 2);

    // saturation, hold, clear against a coincident hit
    repeat (9) step(1'b1, 4'b0000, GATE_OR, 1'b0);
    idle();
    idle();
    chk("s5_hit_sat", int'(hit_count), 7);
    chk("s5_sat", int'(count_sat), 1);
    idle();
    chk("s5_hit_hold", int'(hit_count), 7);
    step(1'b1, 4'b0000, GATE_OR, 1'b0);
    idle();
    step(1'b0, 4'b0000, GATE_AND, 1'b1);
    chk("s5_clr_hit", int'(hit_count), 0);
    chk("s5_clr_sat", int'(count_sat), 0);
    step(1'b1, 4'b0000, GATE_OR, 1'b0);
    idle();
    step(1'b0, 4'b0000, GATE_AND, 1'b1);
    chk("s5_clr_wins", int'(hit_count), 0);
    idle();
    chk("s5_clr_lost", int'(hit_count), 0);

    // asynchronous reset with two samples in flight
    repeat (3) step(1'b1, 4'b0000, GATE_OR, 1'b0);
    chk("s6_pre_valid", int'(out_valid), 1);
    chk("s6_pre_hit", int'(hit_count), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("s6_async_valid", int'(out_valid), 0);
    chk("s6_async_result", int'(result), 0);
    chk("s6_async_rise", int'(rise), 0);
    chk("s6_async_hit", int'(hit_count), 0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) begin
      idle();
      chk("s6_no_ghost", int'(out_valid), 0);
    end
    step(1'b1, 4'b0000, GATE_OR, 1'b0);
    chk("s6_latency_early", int'(out_valid), 0);
    idle();
    chk("s6_new_valid", int'(out_valid), 1);
    chk("s6_new_rise", int'(rise), 1);
    idle();
    chk("s6_new_hit", int'(hit_count), 1);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
